// File: rtl/serving_bridge_pkg.sv
// Shared constants and state encoding for the serving bridge initiator.
// Status bytes are what the host sees after each frame.
package serving_bridge_pkg;

    localparam logic [2:0] HDR_MAGIC = 3'b101;

    localparam logic [7:0] ACK_OK = 8'hA5;
    localparam logic [7:0] ACK_TO = 8'hEE;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {
        S_HDR,
        S_ADR0,
        S_ADR1,
        S_DAT,
        S_BUS,
        S_RSP,
        S_RDAT,
        S_NAK
    } state_t;

endpackage

// File: rtl/serving_bridge_master.sv
// Host byte-frame to single Wishbone transfer bridge; one byte per rx/tx handshake, stb one cycle after the last frame byte.
// Inbound stalls while the transfer and response run; response bytes hold until i_tx_ready accepts them.
module serving_bridge_master
    import serving_bridge_pkg::*;
#(
    parameter int ADR_W   = 11,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic [ADR_W-1:0] o_wb_adr,
    output logic [31:0]      o_wb_dat,
    output logic [3:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_stb,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_ack,
    output logic             o_busy,
    output logic             o_err
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

    state_t           state, state_d;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       status;
    logic [31:0]      rdt;
    logic             rx_fire, tx_fire, hdr_ok, bus_to;

    assign rx_fire = i_rx_valid && o_rx_ready;
    assign tx_fire = o_tx_valid && i_tx_ready;
    assign hdr_ok  = (i_rx_data[6:4] == HDR_MAGIC);
    // The last permitted stb cycle is the one where cnt reaches TIMEOUT-1; an ack there still wins.
    assign bus_to  = (state == S_BUS) && !i_wb_ack && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state;
        o_rx_ready = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_wb_stb   = 1'b0;
        o_busy     = (state != S_HDR);
        case (state)
            S_HDR: begin
                o_rx_ready = 1'b1;
                if (rx_fire) state_d = hdr_ok ? S_ADR0 : S_NAK;
            end
            S_ADR0: begin
                o_rx_ready = 1'b1;
                if (rx_fire) state_d = S_ADR1;
            end
            S_ADR1: begin
                o_rx_ready = 1'b1;
                if (rx_fire) state_d = o_wb_we ? S_DAT : S_BUS;
            end
            S_DAT: begin
                o_rx_ready = 1'b1;
                if (rx_fire && idx == 2'd3) state_d = S_BUS;
            end
            S_BUS: begin
                o_wb_stb = 1'b1;
                if (i_wb_ack || bus_to) state_d = S_RSP;
            end
            S_RSP: begin
                o_tx_valid = 1'b1;
                o_tx_data  = status;
                if (tx_fire) state_d = (!o_wb_we && status == ACK_OK) ? S_RDAT : S_HDR;
            end
            S_RDAT: begin
                o_tx_valid = 1'b1;
                o_tx_data  = rdt[{idx, 3'b000} +: 8];
                if (tx_fire && idx == 2'd3) state_d = S_HDR;
            end
            S_NAK: begin
                o_tx_valid = 1'b1;
                o_tx_data  = NAK;
                if (tx_fire) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_HDR;
            idx      <= 2'd0;
            cnt      <= '0;
            status   <= 8'h00;
            rdt      <= 32'h0;
            o_wb_adr <= '0;
            o_wb_dat <= 32'h0;
            o_wb_sel <= 4'h0;
            o_wb_we  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= '0;
            case (state)
                S_HDR: begin
                    if (rx_fire) begin
                        if (hdr_ok) begin
                            o_wb_we  <= i_rx_data[7];
                            o_wb_sel <= i_rx_data[3:0];
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                S_ADR0: if (rx_fire) o_wb_adr[7:0] <= i_rx_data;
                S_ADR1: begin
                    if (rx_fire) begin
                        o_wb_adr[ADR_W-1:8] <= i_rx_data[ADR_W-9:0];
                        idx                 <= 2'd0;
                    end
                end
                S_DAT: begin
                    if (rx_fire) begin
                        o_wb_dat[{idx, 3'b000} +: 8] <= i_rx_data;
                        idx                          <= idx + 2'd1;
                    end
                end
                S_BUS: begin
                    cnt <= cnt + 1'b1;
                    if (i_wb_ack) begin
                        status <= ACK_OK;
                        if (!o_wb_we) rdt <= i_wb_rdt;
                    end else if (bus_to) begin
                        status <= ACK_TO;
                        o_err  <= 1'b1;
                    end
                end
                S_RSP:  idx <= 2'd0;
                S_RDAT: if (tx_fire) idx <= idx + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serving_bridge_master.md
Name: serving_bridge_master

Overview:
- Bridge initiator that drives the serving SoC's external bridge slave port (adr_brg/data_brg/stb_brg/wen_brg/sel_brg in; rdt_brg/ack_brg out).
- Decodes a byte-stream command frame from a host link (UART/SPI front end, valid/ready) into one Wishbone-style single transfer.
- Returns a status byte, plus read data for reads, on an outbound byte stream.
- Used for program load and memory inspection of the 8-bit SRAM while the core is held off (mux selects driven externally).

Parameters:
ADR_W, 11, word-address width; the bus carries address bits [12:2].
TIMEOUT, 255, maximum cycles stb is held waiting for ack (8-bit counter minimum; must be >= 16).

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_rx_data  in  8  command byte from host link
i_rx_valid  in  1  command byte valid
o_rx_ready  out  1  block accepts command byte
o_tx_data  out  8  response byte to host link
o_tx_valid  out  1  response byte valid
i_tx_ready  in  1  host link accepts response byte
o_wb_adr  out  ADR_W  word address, drives adr_brg
o_wb_dat  out  32  write data, drives data_brg
o_wb_sel  out  4  byte select, drives sel_brg
o_wb_we  out  1  write enable, drives wen_brg
o_wb_stb  out  1  strobe, drives stb_brg
i_wb_rdt  in  32  read data from rdt_brg
i_wb_ack  in  1  ack from ack_brg
o_busy  out  1  frame in progress (state != HDR)
o_err  out  1  sticky error: timeout or bad header; cleared only by reset

Behaviour:
- Reset is i_rst, synchronous, active-high; clock is i_clk.
- Reset values:
  - state=HDR
  - o_wb_stb=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0
  - o_tx_valid=0, o_tx_data=0
  - o_rx_ready=1, o_busy=0, o_err=0
- Reset mid-frame or mid-transfer discards the partial frame and drops stb the next cycle.
- Byte handshakes: a transfer occurs when valid and ready are both high at a clock edge.
  - o_tx_data and o_tx_valid stay stable until accepted.
  - o_rx_ready is high only in HDR, ADR0, ADR1 and DAT.
- Frame layout:
  - Byte 0 (header): bit7=we, bits6:4 must be 3'b101, bits3:0=sel.
  - Byte 1: adr[7:0].
  - Byte 2: adr[ADR_W-1:8]; unused upper bits are ignored.
  - Writes only: bytes 3..6 are dat[7:0], dat[15:8], dat[23:16], dat[31:24].
- States:
  - HDR: on accepted byte, if bits6:4 != 3'b101, set o_err and go to NAK; otherwise latch we/sel and go to ADR0.
  - ADR0 -> ADR1 -> (we ? DAT : BUS).
  - DAT: 2-bit index counts 0..3; after the 4th byte go to BUS.
  - BUS:
    - o_wb_stb=1 is registered and asserted the first cycle in BUS; adr/dat/sel/we are stable while stb is high.
    - The timeout counter starts at 0 and increments each BUS cycle.
    - On i_wb_ack=1: deassert stb next cycle and latch i_wb_rdt if read; go to RSP with status 0xA5.
    - If the counter reaches TIMEOUT with no ack: deassert stb, set o_err, go to RSP with status 0xEE.
    - A simultaneous ack and timeout counts as ack.
  - RSP: present the status byte. When accepted:
    - read with status 0xA5 -> RDAT
    - any other case -> HDR
  - RDAT: present 4 bytes rdt[7:0] first through rdt[31:24]; 2-bit index; return to HDR after the 4th is accepted.
  - NAK: present 0x15, then return to HDR.
- i_wb_ack outside BUS is ignored, including a trailing duplicate ack after stb falls.
- At least one stb-low cycle separates transfers; this is guaranteed by the RSP state.
- sel is passed through unmodified.
  - sel=4'b1111 transfers may take up to 10 cycles before ack; the block waits without interpreting sel.
  - sel=4'b0000 is still issued on the bus.

Decomposition:
- Package serving_bridge_pkg holds:
  - header magic 3'b101
  - status constants ACK_OK=8'hA5, ACK_TO=8'hEE, NAK=8'h15
  - state enum (HDR, ADR0, ADR1, DAT, BUS, RSP, RDAT, NAK)
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
- Write word: rx 0xDF,0x10,0x00,0x78,0x56,0x34,0x12 -> one stb window with adr=0x010, sel=1111, we=1, dat=0x12345678. Responder acks after 4 cycles -> tx 0xA5.
- Read word: rx 0x5F,0x10,0x00 with responder rdt=0x12345678, ack after 10 cycles -> tx 0xA5,0x78,0x56,0x34,0x12; o_err stays 0.
- Byte write: rx 0xD1,0x03,0x00,0xAA,0,0,0 -> sel=0001, adr=0x003; stb drops the cycle after ack; a duplicate ack one cycle later is ignored; exactly one 0xA5 is returned.
- Bad header: rx 0x80 -> tx 0x15, o_err=1, state back to HDR; a following valid frame completes normally.
- Timeout: read with ack never asserted -> stb high for exactly TIMEOUT=255 cycles, then tx 0xEE only, o_err=1.
- Reset and backpressure:
  - Pulse i_rst after 2 bytes -> stb=0, o_busy=0, and the next full frame decodes correctly.
  - Hold i_tx_ready=0 for 20 cycles during RDAT -> o_tx_data is held, with no lost or duplicated bytes.
